fft8_frame_scheduler: RTL and testbench

FFT8_FRAME_SCHEDULER -- requirements
Module: fft8_frame_scheduler

---
 rtl/fft8_frame_scheduler.sv | 155 +++++++++++++++
 tb/tb_fft8_frame_scheduler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_scheduler.sv
// Two-requester frame scheduler for an 8-point FFT: gathers eight samples from the
// round-robin winner, launches the FFT, waits with a timeout and streams the bins back.
module fft8_frame_scheduler #(
    parameter int DW      = 24,
    parameter int FFT_LAT = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  logic [DW-1:0]   s0_real,
    input  logic [DW-1:0]   s0_imag,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [DW-1:0]   s1_real,
    input  logic [DW-1:0]   s1_imag,
    output logic            fft_en,
    output logic [8*DW-1:0] fft_x_real,
    output logic [8*DW-1:0] fft_x_imag,
    input  logic            fft_valid,
    input  logic [8*DW-1:0] fft_y_real,
    input  logic [8*DW-1:0] fft_y_imag,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_real,
    output logic [DW-1:0]   m_imag,
    output logic [2:0]      m_idx,
    output logic            m_chan,
    output logic            m_last,
    output logic            busy,
    output logic            err
);

    // Wait counter must cover the timeout window and the nominal FFT latency.
    localparam int WAIT_SPAN = (TIMEOUT > FFT_LAT + 1) ? TIMEOUT : FFT_LAT + 1;
    localparam int WCW       = $clog2(WAIT_SPAN + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT, UNLOAD} state_t;

    state_t          state_reg, state_next;
    logic            grant_reg, grant_next;
    logic            rr_reg, rr_next;
    logic [2:0]      cnt_reg;
    logic [2:0]      idx_reg;
    logic [WCW-1:0]  wcnt_reg;
    logic            err_reg;
    logic [8*DW-1:0] y_re_flat, y_im_flat;

    logic            accept, unload_hs, capture, timeout_hit;
    logic [DW-1:0]   load_re, load_im;

    assign accept      = (state_reg == LOAD) && (grant_reg ? s1_valid : s0_valid);
    assign unload_hs   = (state_reg == UNLOAD) && m_ready;
    assign capture     = (state_reg == WAIT) && fft_valid;
    assign timeout_hit = (state_reg == WAIT) && !fft_valid && (wcnt_reg == WAIT_LAST);
    assign load_re     = grant_reg ? s1_real : s0_real;
    assign load_im     = grant_reg ? s1_imag : s0_imag;

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        rr_next    = rr_reg;
        case (state_reg)
            IDLE: begin
                // rr_reg names the channel favoured on a tie.
                if (s0_valid || s1_valid) begin
                    grant_next = (s0_valid && s1_valid) ? rr_reg : s1_valid;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (accept && (cnt_reg == 3'd7)) state_next = LAUNCH;
            end
            LAUNCH: state_next = WAIT;
            WAIT: begin
                if (capture) begin
                    state_next = UNLOAD;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    rr_next    = ~grant_reg;
                end
            end
            UNLOAD: begin
                if (unload_hs && (idx_reg == 3'd7)) begin
                    state_next = IDLE;
                    rr_next    = ~grant_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            rr_reg    <= 1'b0;
            cnt_reg   <= 3'd0;
            idx_reg   <= 3'd0;
            wcnt_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            rr_reg    <= rr_next;
            if (accept)    cnt_reg <= cnt_reg + 3'd1;
            if (unload_hs) idx_reg <= idx_reg + 3'd1;
            wcnt_reg  <= (state_reg == WAIT) ? wcnt_reg + 1'b1 : '0;
            err_reg   <= timeout_hit;
        end
    end

    // One input slot and one result bin per FFT point.
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
        logic [DW-1:0] x_re_reg, x_im_reg, y_re_reg, y_im_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                x_re_reg <= '0;
                x_im_reg <= '0;
                y_re_reg <= '0;
                y_im_reg <= '0;
            end else begin
                if (accept && (cnt_reg == 3'(gi))) begin
                    x_re_reg <= load_re;
                    x_im_reg <= load_im;
                end
                if (capture) begin
                    y_re_reg <= fft_y_real[gi*DW +: DW];
                    y_im_reg <= fft_y_imag[gi*DW +: DW];
                end
            end
        end

        assign fft_x_real[gi*DW +: DW] = x_re_reg;
        assign fft_x_imag[gi*DW +: DW] = x_im_reg;
        assign y_re_flat[gi*DW +: DW]  = y_re_reg;
        assign y_im_flat[gi*DW +: DW]  = y_im_reg;
    end

    assign s0_ready = (state_reg == LOAD) && !grant_reg;
    assign s1_ready = (state_reg == LOAD) && grant_reg;
    assign fft_en   = (state_reg == LAUNCH);
    assign busy     = (state_reg != IDLE);
    assign err      = err_reg;
    assign m_valid  = (state_reg == UNLOAD);
    assign m_idx    = idx_reg;
    assign m_real   = m_valid ? y_re_flat[idx_reg*DW +: DW] : '0;
    assign m_imag   = m_valid ? y_im_flat[idx_reg*DW +: DW] : '0;
    assign m_chan   = m_valid && grant_reg;
    assign m_last   = m_valid && (idx_reg == 3'd7);

endmodule

// File: tb/tb_fft8_frame_scheduler.sv
// Bench for fft8_frame_scheduler: echo FFT stub, frame-level scoreboard,
// arbitration table, directed corner sequences and a randomized run.
module tb_fft8_frame_scheduler;

    localparam int DW      = 24;
    localparam int FFT_LAT = 3;
    localparam int TIMEOUT = 16;
    localparam int NS      = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            s0_valid = 0, s1_valid = 0, m_ready = 0;
    logic            s0_ready, s1_ready;
    logic [DW-1:0]   s0_real = '0, s0_imag = '0, s1_real = '0, s1_imag = '0;
    logic            fft_en, fft_valid;
    logic [8*DW-1:0] fft_x_real, fft_x_imag, fft_y_real, fft_y_imag;
    logic            m_valid, m_chan, m_last, busy, err;
    logic [DW-1:0]   m_real, m_imag;
    logic [2:0]      m_idx;

    fft8_frame_scheduler #(.DW(DW), .FFT_LAT(FFT_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_real(s0_real), .s0_imag(s0_imag),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_real(s1_real), .s1_imag(s1_imag),
        .fft_en(fft_en), .fft_x_real(fft_x_real), .fft_x_imag(fft_x_imag),
        .fft_valid(fft_valid), .fft_y_real(fft_y_real), .fft_y_imag(fft_y_imag),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .m_idx(m_idx), .m_chan(m_chan), .m_last(m_last), .busy(busy), .err(err)
    );

    // Echo FFT stub: y = x, fft_valid FFT_LAT cycles after fft_en.
    logic               stub_on = 1'b1;
    logic               stray   = 1'b0;
    logic [FFT_LAT-1:0] pipe;
    logic [8*DW-1:0]    y_re_lat, y_im_lat;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe     <= '0;
            y_re_lat <= '0;
            y_im_lat <= '0;
        end else begin
            pipe <= {pipe[FFT_LAT-2:0], fft_en & stub_on};
            if (fft_en) begin
                y_re_lat <= fft_x_real;
                y_im_lat <= fft_x_imag;
            end
        end
    end
    assign fft_valid  = pipe[FFT_LAT-1] | stray;
    assign fft_y_real = y_re_lat;
    assign fft_y_imag = y_im_lat;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Source streams and frame-level reference model.
    logic [DW-1:0] src_re [2][NS];
    logic [DW-1:0] src_im [2][NS];
    int     ptr [2]       = '{0, 0};
    int     consumed [2]  = '{0, 0};
    int     acc_total [2] = '{0, 0};
    bit     exp_chan_q [$];
    bit     out_chan_log [$];
    bit     last_served = 1'b1;
    int     bin_k = 0, frames_out = 0, fen_cnt = 0, err_cnt = 0, mv_cycles = 0;
    int     hs_total = 0, acc_in_frame = 0;
    longint cyc = 0, last8_cyc = -100, fen_cyc = 0, err_cyc = 0;
    bit     prev_busy = 0, prev_v0 = 0, prev_v1 = 0, prev_mv = 0, prev_mr = 0, prev_rdy = 0;
    logic [52:0] prev_mbus = '0;
    bit     mc, ec;
    int     mk;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            consumed[0]  = ptr[0];
            consumed[1]  = ptr[1];
            exp_chan_q.delete();
            last_served  = 1'b1;
            bin_k        = 0;
            acc_in_frame = 0;
            prev_busy    = 0;
            prev_mv      = 0;
            prev_mr      = 0;
            prev_rdy     = 0;
        end else begin
            // Tie goes to the channel not served last; a lone requester always wins.
            if (busy && !prev_busy) begin
                check("arb_request", {63'd0, prev_v0 | prev_v1}, 64'd1);
                ec = (prev_v0 && prev_v1) ? !last_served : prev_v1;
                exp_chan_q.push_back(ec);
                last_served = ec;
            end
            if (!busy)
                check("idle_outputs", {60'd0, s1_ready, s0_ready, m_valid, fft_en}, 64'd0);
            else if ((s0_ready || s1_ready) && exp_chan_q.size() > 0)
                check("ready_grant", {62'd0, s1_ready, s0_ready},
                      exp_chan_q[$] ? 64'd2 : 64'd1);
            for (int c = 0; c < 2; c++) begin
                if ((c == 0) ? (s0_valid && s0_ready) : (s1_valid && s1_ready)) begin
                    ptr[c]++;
                    acc_total[c]++;
                    acc_in_frame++;
                    if (acc_in_frame == 8) begin
                        acc_in_frame = 0;
                        last8_cyc    = cyc;
                    end
                end
            end
            if (fft_en) begin
                fen_cnt++;
                fen_cyc = cyc;
                check("fft_en_latency", cyc - last8_cyc, 64'd1);
            end
            if (m_valid) begin
                mv_cycles++;
                if (!prev_mv) check("m_valid_latency", cyc - last8_cyc, 64'd5);
            end
            if (prev_mv && !prev_mr)
                check("hold_stable", {11'd0, m_valid, m_idx, m_chan, m_last, m_real, m_imag},
                      {11'd0, 1'b1, prev_mbus});
            if (m_valid && m_ready) begin
                hs_total++;
                if (exp_chan_q.size() == 0) begin
                    check("bin_unexpected", 64'd1, 64'd0);
                end else begin
                    mc = exp_chan_q[0];
                    mk = (consumed[mc] + bin_k) % NS;
                    check("bin_chan", {63'd0, m_chan}, {63'd0, mc});
                    check("bin_idx", {61'd0, m_idx}, bin_k);
                    check("bin_last", {63'd0, m_last}, {63'd0, bin_k == 7});
                    check("bin_real", m_real, src_re[mc][mk]);
                    check("bin_imag", m_imag, src_im[mc][mk]);
                    bin_k++;
                    if (bin_k == 8) begin
                        bin_k = 0;
                        consumed[mc] += 8;
                        void'(exp_chan_q.pop_front());
                        out_chan_log.push_back(mc);
                        frames_out++;
                        $display("frame %0d ch%0d unloaded at cycle %0d", frames_out, mc, cyc);
                    end
                end
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
                if (exp_chan_q.size() > 0) begin
                    mc = exp_chan_q.pop_front();
                    consumed[mc] += 8;
                    $display("frame ch%0d timed out at cycle %0d", mc, cyc);
                end
            end
            prev_busy = busy;
            prev_v0   = s0_valid;
            prev_v1   = s1_valid;
            prev_mv   = m_valid;
            prev_mr   = m_ready;
            prev_rdy  = s0_ready | s1_ready;
            prev_mbus = {m_idx, m_chan, m_last, m_real, m_imag};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        s0_real = src_re[0][ptr[0] % NS];
        s0_imag = src_im[0][ptr[0] % NS];
        s1_real = src_re[1][ptr[1] % NS];
        s1_imag = src_im[1][ptr[1] % NS];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_outputs",
              {51'd0, s0_ready, s1_ready, fft_en, m_valid, m_last, busy, err, m_chan, m_idx,
               |fft_x_real, |fft_x_imag, |m_real, |m_imag}, 64'd0);
        s0_valid = 0;
        s1_valid = 0;
        m_ready  = 0;
        stray    = 0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic run_load(input bit both, input bit ch, input bit toggle);
        int base;
        bit ph;
        base = acc_total[0] + acc_total[1];
        ph   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (acc_total[0] + acc_total[1] - base >= 8) break;
            s0_valid = (both || ch == 1'b0) && ph;
            s1_valid = (both || ch == 1'b1) && ph;
            if (toggle) ph = !ph;
            tick();
        end
        s0_valid = 0;
        s1_valid = 0;
        check("load_accepts", acc_total[0] + acc_total[1] - base, 64'd8);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 400 && frames_out < n; i++) tick();
        check("frames_reached", {63'd0, frames_out >= n}, 64'd1);
    endtask

    typedef struct packed {
        logic       v0;
        logic       v1;
        logic [1:0] rdy;
        logic       bsy;
    } arb_vec_t;
    arb_vec_t tbl [4];

    initial begin
        int f0, fen0, e0, mv0, hs0, fb;
        bit found;
        logic [DW-1:0] all_ones;
        all_ones = '1;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < NS; i++) begin
                src_re[c][i] = DW'($urandom);
                src_im[c][i] = DW'($urandom);
            end
        #2;
        do_reset();

        // Arbitration from a fresh reset: {s0_valid, s1_valid} -> readiness one cycle later.
        tbl[0] = '{1'b0, 1'b0, 2'b00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 2'b01, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 2'b10, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 2'b01, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            s0_valid = tbl[i].v0;
            s1_valid = tbl[i].v1;
            @(negedge clk);
            check("arb_idle_ready", {62'd0, s1_ready, s0_ready}, 64'd0);
            tick();
            @(negedge clk);
            check("arb_ready", {62'd0, s1_ready, s0_ready}, {62'd0, tbl[i].rdy});
            check("arb_busy", {63'd0, busy}, {63'd0, tbl[i].bsy});
        end

        // Ramp frame on ch0: real 0..7, imag -1.
        do_reset();
        m_ready = 1;
        for (int k = 0; k < 8; k++) begin
            src_re[0][(ptr[0] + k) % NS] = DW'(k);
            src_im[0][(ptr[0] + k) % NS] = all_ones;
        end
        fen0 = fen_cnt;
        f0   = frames_out;
        run_load(1'b0, 1'b0, 1'b0);
        wait_frames(f0 + 1);
        check("ramp_fft_en_count", fen_cnt - fen0, 64'd1);
        check("ramp_chan", {63'd0, out_chan_log[f0]}, 64'd0);

        // Both requesters held high: ch0, ch1, ch0.
        do_reset();
        m_ready  = 1;
        f0       = frames_out;
        s0_valid = 1;
        s1_valid = 1;
        for (int i = 0; i < 400 && frames_out < f0 + 3; i++) tick();
        s0_valid = 0;
        s1_valid = 0;
        check("rr_frames", {63'd0, frames_out >= f0 + 3}, 64'd1);
        if (frames_out >= f0 + 3) begin
            check("rr_order0", {63'd0, out_chan_log[f0]}, 64'd0);
            check("rr_order1", {63'd0, out_chan_log[f0 + 1]}, 64'd1);
            check("rr_order2", {63'd0, out_chan_log[f0 + 2]}, 64'd0);
        end

        // Back-pressure for 5 cycles at bin 3.
        do_reset();
        m_ready = 1;
        fb      = ptr[0];
        f0      = frames_out;
        hs0     = hs_total;
        run_load(1'b0, 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_valid && m_idx == 3'd2) begin
                found = 1;
                break;
            end
        end
        check("stall_reach_idx2", {63'd0, found}, 64'd1);
        tick();
        m_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_idx", {61'd0, m_idx}, 64'd3);
            check("stall_real", m_real, src_re[0][(fb + 3) % NS]);
            check("stall_imag", m_imag, src_im[0][(fb + 3) % NS]);
        end
        tick();
        m_ready = 1;
        wait_frames(f0 + 1);
        check("stall_handshakes", hs_total - hs0, 64'd8);

        // FFT never answers: one err pulse 16 cycles after WAIT entry, then a ch1 tie-break.
        do_reset();
        stub_on = 0;
        m_ready = 1;
        e0      = err_cnt;
        mv0     = mv_cycles;
        run_load(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && err_cnt == e0; i++) tick();
        repeat (3) tick();
        @(negedge clk);
        check("timeout_err_count", err_cnt - e0, 64'd1);
        check("timeout_err_delay", err_cyc - fen_cyc, 64'd17);
        check("timeout_no_m_valid", mv_cycles - mv0, 64'd0);
        check("timeout_idle", {63'd0, busy}, 64'd0);
        stub_on = 1;
        f0 = frames_out;
        run_load(1'b1, 1'b0, 1'b0);
        wait_frames(f0 + 1);
        check("timeout_next_chan", {63'd0, out_chan_log[f0]}, 64'd1);

        // Asynchronous reset during ch1 unload at bin 4.
        do_reset();
        m_ready  = 1;
        s0_valid = 1;
        s1_valid = 1;
        found    = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_valid && m_chan && m_idx == 3'd4) begin
                found = 1;
                break;
            end
            tick();
        end
        check("areset_reach_idx4", {63'd0, found}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("areset_outputs", {60'd0, m_valid, busy, s0_ready, s1_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;
        f0  = frames_out;
        wait_frames(f0 + 1);
        s0_valid = 0;
        s1_valid = 0;
        check("areset_next_chan", {63'd0, out_chan_log[f0]}, 64'd0);

        // s0_valid toggling every cycle during LOAD.
        do_reset();
        m_ready = 1;
        fen0    = fen_cnt;
        f0      = frames_out;
        run_load(1'b0, 1'b0, 1'b1);
        wait_frames(f0 + 1);
        check("toggle_fft_en_count", fen_cnt - fen0, 64'd1);
        check("toggle_chan", {63'd0, out_chan_log[f0]}, 64'd0);

        // Randomized traffic with stray fft_valid outside WAIT.
        do_reset();
        f0 = frames_out;
        for (int i = 0; i < 2000; i++) begin
            s0_valid = ($urandom % 4) != 0;
            s1_valid = ($urandom % 3) != 0;
            m_ready  = ($urandom % 4) != 0;
            stray    = (prev_mv || prev_rdy) && (($urandom % 6) == 0);
            tick();
        end
        stray   = 0;
        m_ready = 1;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            s0_valid = s0_ready;
            s1_valid = s1_ready;
            tick();
        end
        s0_valid = 0;
        s1_valid = 0;
        repeat (2) tick();
        check("rand_frames", {63'd0, frames_out - f0 >= 5}, 64'd1);
        check("rand_drained", {63'd0, busy}, 64'd0);
        check("rand_queue_empty", exp_chan_q.size(), 64'd0);
        check("rand_ch0_consumed", consumed[0], ptr[0]);
        check("rand_ch1_consumed", consumed[1], ptr[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
